// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with bit-serial shifts and an optional shift-add
// multiplier that is built only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             zero,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_SUBU = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  // Handshake: a request is taken on a rising edge with start=1 and busy=0;
  // start while busy=1 is dropped. done pulses one cycle as r/flags update.
  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_init;
  logic             accept;
  logic             step;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] res_r;
  logic             of_add;
  logic             of_sub;
  logic             res_of;
  logic             res_err;
`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;
`endif

  assign accept = start && !busy;
  assign step   = (cnt != '0);

  // cnt holds the number of serial steps still to run; zero means one pass.
  always_comb begin
    cnt_init = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: cnt_init = CW'(y[SW-1:0]);
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:                 cnt_init = CW'(WIDTH);
`endif
      default:                cnt_init = '0;
    endcase
  end

  always_comb begin
    sum    = a_q + b_q;
    diff   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    of_add = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    of_sub = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    case (op_q)
      OP_SLL:  sh_step = {a_q[WIDTH-2:0], 1'b0};
      OP_SRA:  sh_step = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: sh_step = {1'b0, a_q[WIDTH-1:1]};
    endcase
`ifdef SEQ_ALU_MUL_EN
    // {hi_q, b_q} is the partial product; b_q doubles as the multiplier.
    mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
    hi_nx   = mul_sum[WIDTH:1];
    lo_nx   = {mul_sum[0], b_q[WIDTH-1:1]};
`endif
    res_r   = '0;
    res_of  = 1'b0;
    res_err = 1'b0;
    case (op_q)
      OP_ADDU: res_r = sum;
      OP_ADD:  begin res_r = sum; res_of = of_add; end
      OP_OR:   res_r = a_q | b_q;
      OP_SUBU: res_r = diff[WIDTH-1:0];
      OP_SUB:  begin res_r = diff[WIDTH-1:0]; res_of = of_sub; end
      OP_SLTU: res_r = WIDTH'(!diff[WIDTH]);
      OP_SLT:  res_r = WIDTH'(of_sub ^ diff[WIDTH-1]);
      OP_AND:  res_r = a_q & b_q;
      OP_XOR:  res_r = a_q ^ b_q;
      OP_SLL, OP_SRL, OP_SRA: res_r = step ? sh_step : a_q;
`ifdef SEQ_ALU_MUL_EN
      OP_MUL:  begin res_r = lo_nx; res_of = |hi_nx; end
`endif
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      r        <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      err      <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
`ifdef SEQ_ALU_MUL_EN
      hi_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        EXEC: begin
          if (step) begin
            cnt <= cnt - CW'(1);
            if (op_q == OP_SLL || op_q == OP_SRL || op_q == OP_SRA) a_q <= sh_step;
`ifdef SEQ_ALU_MUL_EN
            if (op_q == OP_MUL) begin
              hi_q <= hi_nx;
              b_q  <= lo_nx;
            end
`endif
          end
          if (cnt <= CW'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            r        <= res_r;
            overflow <= res_of;
            zero     <= (res_r == '0);
            err      <= res_err;
          end
        end
        default: begin
          if (accept) begin
            state <= EXEC;
            busy  <= 1'b1;
            op_q  <= op;
            a_q   <= x;
            b_q   <= y;
            cnt   <= cnt_init;
`ifdef SEQ_ALU_MUL_EN
            hi_q  <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: cycle-by-cycle compare against a behavioural model,
// directed literal cases, then randomized requests with input noise.
module tb_seq_alu;
  localparam int WIDTH = 32;
  localparam logic [3:0] ADDU = 4'h0, ADD = 4'h1, SUB = 4'h5, SLTU = 4'h6, SLT = 4'h7;
  localparam logic [3:0] SLL = 4'hA, SRA = 4'hC, MUL = 4'hD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       op = 4'h0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             busy, done, overflow, zero, err;
  logic [WIDTH-1:0] r;

  int n_chk = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
    .busy(busy), .done(done), .r(r), .overflow(overflow), .zero(zero), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results straight from the arithmetic definitions.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] er, output logic eof, output logic eerr,
                                output int lat);
    longint s;
    logic [63:0] p;
    int sh;
    sh = int'(b[4:0]);
    er = '0; eof = 1'b0; eerr = 1'b0; lat = 1;
    case (o)
      4'h0: er = a + b;
      4'h1: begin s = longint'($signed(a)) + longint'($signed(b)); er = s[31:0];
                  eof = (s != longint'($signed(s[31:0]))); end
      4'h2: er = a | b;
      4'h4: er = a - b;
      4'h5: begin s = longint'($signed(a)) - longint'($signed(b)); er = s[31:0];
                  eof = (s != longint'($signed(s[31:0]))); end
      4'h6: er = (a < b) ? 32'd1 : 32'd0;
      4'h7: er = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: er = a & b;
      4'h9: er = a ^ b;
      4'hA: begin er = a << sh; lat = (sh == 0) ? 1 : sh; end
      4'hB: begin er = a >> sh; lat = (sh == 0) ? 1 : sh; end
      4'hC: begin er = $signed(a) >>> sh; lat = (sh == 0) ? 1 : sh; end
`ifdef SEQ_ALU_MUL_EN
      4'hD: begin p = {32'b0, a} * {32'b0, b}; er = p[31:0]; eof = |p[63:32]; lat = 32; end
`endif
      default: eerr = 1'b1;
    endcase
  endfunction

  // scoreboard: expected outputs tracked per cycle, results queued per request
  logic [WIDTH-1:0] exp_q[$];
  logic [1:0]       flag_q[$];
  int               m_rem = 0;
  logic             m_done = 1'b0;
  logic [31:0]      m_r = '0;
  logic             m_of = 1'b0, m_zero = 1'b0, m_err = 1'b0;

  always @(negedge clk) begin : compare
    logic [31:0] er;
    logic eof, eerr, was_busy;
    int lat;
    if (!rst_n) begin
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_r", r, 0);
      chk("rst_of", overflow, 0); chk("rst_zero", zero, 0); chk("rst_err", err, 0);
      m_rem = 0; m_done = 1'b0; m_r = '0; m_of = 1'b0; m_zero = 1'b0; m_err = 1'b0;
      exp_q.delete(); flag_q.delete();
    end else begin
      chk("busy", busy, m_rem > 0); chk("done", done, m_done); chk("r", r, m_r);
      chk("overflow", overflow, m_of); chk("zero", zero, m_zero); chk("err", err, m_err);
      was_busy = (m_rem > 0);
      m_done = 1'b0;
      if (m_rem == 1 && exp_q.size() > 0) begin
        m_done = 1'b1;
        m_r = exp_q.pop_front();
        {m_of, m_err} = flag_q.pop_front();
        m_zero = (m_r == '0);
      end
      if (m_rem > 0) m_rem--;
      if (!was_busy && start) begin
        model(op, x, y, er, eof, eerr, lat);
        exp_q.push_back(er);
        flag_q.push_back({eof, eerr});
        m_rem = lat;
      end
    end
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; x = a; y = b;
    @(posedge clk); #2;
    start = 1'b0; op = 4'($urandom); x = $urandom; y = $urandom;
  endtask

  task automatic wait_done(input int mode, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
      if (!done && busy && mode == 1) begin
        start = 1'($urandom_range(0, 1)); op = 4'($urandom); x = $urandom; y = $urandom;
      end else if (!done && busy && mode == 2) begin
        start = 1'b1; x = $urandom; y = $urandom;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 100);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic expect_res(input string name, input logic [31:0] er, input logic eof,
                            input logic ez, input logic eerr, input int elat, input int lat);
    chk({name, "_r"}, r, er); chk({name, "_of"}, overflow, eof);
    chk({name, "_zero"}, zero, ez); chk({name, "_err"}, err, eerr);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
  endtask

  initial begin
    int lat;
    logic [3:0] o;
    logic [31:0] a, b;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    issue(ADD, 32'h7FFF_FFFF, 32'h0000_0001); wait_done(0, lat);
    expect_res("add_ovf", 32'h8000_0000, 1, 0, 0, 1, lat);
    issue(SUB, 32'd5, 32'd5); wait_done(1, lat);
    expect_res("sub_eq", 32'h0, 0, 1, 0, 1, lat);
    issue(SLT, 32'hFFFF_FFFF, 32'd1); wait_done(0, lat);
    expect_res("slt", 32'd1, 0, 0, 0, 1, lat);
    issue(SLTU, 32'hFFFF_FFFF, 32'd1); wait_done(0, lat);
    expect_res("sltu", 32'd0, 0, 1, 0, 1, lat);
    issue(SRA, 32'h8000_0000, 32'd4); wait_done(1, lat);
    expect_res("sra4", 32'hF800_0000, 0, 0, 0, 4, lat);
    issue(SLL, 32'h1234_5678, 32'd0); wait_done(0, lat);
    expect_res("sll0", 32'h1234_5678, 0, 0, 0, 1, lat);
    issue(4'h3, 32'h1, 32'h2); wait_done(0, lat);
    expect_res("illegal", 32'h0, 0, 1, 1, 1, lat);

    issue(MUL, 32'h0001_0000, 32'h0001_0000); wait_done(2, lat);
`ifdef SEQ_ALU_MUL_EN
    expect_res("mul", 32'h0, 1, 1, 0, 32, lat);
`else
    expect_res("mul_off", 32'h0, 0, 1, 1, 1, lat);
`endif
    chk("b2b_idle", busy, 0);
    issue(ADDU, 32'd3, 32'd4); wait_done(0, lat);
    expect_res("b2b_add", 32'd7, 0, 0, 0, 1, lat);

`ifdef SEQ_ALU_MUL_EN
    issue(MUL, 32'hDEAD_BEEF, 32'h1234_5678);
`else
    issue(SLL, 32'h1, 32'd31);
`endif
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_done", done, 0); chk("rst_mid_r", r, 0);
    chk("rst_mid_of", overflow, 0); chk("rst_mid_zero", zero, 0); chk("rst_mid_err", err, 0);
    @(posedge clk); #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    issue(ADD, 32'd1, 32'd1); wait_done(0, lat);
    expect_res("post_rst_add", 32'd2, 0, 0, 0, 1, lat);

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      issue(o, a, b);
      wait_done(int'($urandom_range(0, 2)), lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
    end
    repeat (3) begin @(posedge clk); #2; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
